// File: rtl/dcache_sa_controller.sv
// N-way set-associative write-back, write-allocate data cache controller.
// True-LRU replacement, dirty-victim writeback, pipeline stall on miss.
module dcache_sa_controller #(
    parameter int WAYS      = 2,
    parameter int SETS      = 16,
    parameter int LINE_BITS = 256,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_W-1:0]    cpu_addr_i,
    input  logic [DATA_W-1:0]    cpu_data_i,
    input  logic                 cpu_MemRead_i,
    input  logic                 cpu_MemWrite_i,
    output logic [DATA_W-1:0]    cpu_data_o,
    output logic                 cpu_stall_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o
);

    localparam int OFF    = $clog2(LINE_BITS / 8);
    localparam int IDX    = $clog2(SETS);
    localparam int TAG    = ADDR_W - OFF - IDX;
    localparam int WORD_W = $clog2(LINE_BITS / DATA_W);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_WAIT,
        FILL_REQ,
        FILL_WAIT,
        REFILL
    } state_t;

    state_t state;
    state_t state_nx;

    logic [LINE_BITS-1:0] lines [SETS][WAYS];
    logic [TAG-1:0]       tags  [SETS][WAYS];
    logic [WAYS-1:0]      valid [SETS];
    logic [WAYS-1:0]      dirty [SETS];
    logic [WAY_W-1:0]     age   [SETS][WAYS];

    logic [WAY_W-1:0]     victim;
    logic [WAY_W-1:0]     victim_c;
    logic                 victim_found;
    logic [LINE_BITS-1:0] fill_buf;

    logic                 req;
    logic                 store;
    logic [IDX-1:0]       idx;
    logic [TAG-1:0]       tag;
    logic [WORD_W-1:0]    word;
    logic                 hit;
    logic [WAY_W-1:0]     hit_way;
    logic                 upd_en;
    logic [WAY_W-1:0]     upd_way;
    logic [ADDR_W-1:0]    victim_addr;
    logic [ADDR_W-1:0]    req_addr;
    logic                 unused_bits;

    assign req         = cpu_MemRead_i | cpu_MemWrite_i;
    assign store       = cpu_MemWrite_i;
    assign idx         = cpu_addr_i[OFF +: IDX];
    assign tag         = cpu_addr_i[OFF+IDX +: TAG];
    assign word        = cpu_addr_i[2 +: WORD_W];
    assign unused_bits = ^cpu_addr_i[1:0];

    assign victim_addr = {tags[idx][victim], idx, {OFF{1'b0}}};
    assign req_addr    = {tag, idx, {OFF{1'b0}}};

    assign upd_en  = (state == IDLE && hit) || (state == REFILL);
    assign upd_way = (state == REFILL) ? victim : hit_way;

    assign cpu_stall_o = req & (~hit | (state != IDLE));

    // Tag lookup across all ways of the addressed set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (req && valid[idx][w] && tags[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: first invalid way, otherwise the oldest way.
    always_comb begin
        victim_c     = '0;
        victim_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (age[idx][w] > age[idx][victim_c]) begin
                victim_c = WAY_W'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && !valid[idx][w]) begin
                victim_c     = WAY_W'(w);
                victim_found = 1'b1;
            end
        end
    end

    // Load data returns the selected word of the hit line only.
    always_comb begin
        cpu_data_o = '0;
        if (hit && !store) begin
            cpu_data_o = lines[idx][hit_way][word*DATA_W +: DATA_W];
        end
    end

    // Miss state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and memory-side outputs.
    always_comb begin
        state_nx     = state;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        unique case (state)
            IDLE: begin
                if (req && !hit) begin
                    state_nx = dirty[idx][victim_c] ? WB_REQ : FILL_REQ;
                end
            end
            WB_REQ: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = victim_addr;
                mem_data_o   = lines[idx][victim];
                state_nx     = WB_WAIT;
            end
            WB_WAIT: begin
                mem_write_o = 1'b1;
                mem_addr_o  = victim_addr;
                mem_data_o  = lines[idx][victim];
                if (mem_ack_i) begin
                    state_nx = FILL_REQ;
                end
            end
            FILL_REQ: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = req_addr;
                state_nx     = FILL_WAIT;
            end
            FILL_WAIT: begin
                mem_addr_o = req_addr;
                if (mem_ack_i) begin
                    state_nx = REFILL;
                end
            end
            REFILL: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Valid, dirty, LRU ages and the latched victim.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            victim <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            if (state == IDLE && req && !hit) begin
                victim <= victim_c;
            end
            if (state == REFILL) begin
                valid[idx][victim] <= 1'b1;
                dirty[idx][victim] <= 1'b0;
            end
            if (state == IDLE && hit && store) begin
                dirty[idx][hit_way] <= 1'b1;
            end
            if (upd_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == upd_way) begin
                        age[idx][w] <= '0;
                    end else if (age[idx][w] < age[idx][upd_way]) begin
                        age[idx][w] <= age[idx][w] + 1'b1;
                    end
                end
            end
        end
    end

    // Line/tag storage, fill capture and store-hit word writes.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state == FILL_WAIT && mem_ack_i) begin
                fill_buf <= mem_data_i;
            end
            if (state == REFILL) begin
                lines[idx][victim] <= fill_buf;
                tags[idx][victim]  <= tag;
            end
            if (state == IDLE && hit && store) begin
                lines[idx][hit_way][word*DATA_W +: DATA_W] <= cpu_data_i;
            end
        end
    end

endmodule
